alu_op_sequencer: RTL

- Issue-side controller for the 32-bit combinational ALU.
- Accepts operation requests over a valid/ready handshake and decodes each opcode into the ALU's 5-bit `controls` word.
- Drives registered operands into the ALU, captures `result_final` and `flags`, and returns them over an output valid/ready handshake.
- Sequences two-pass operations (SUB) that the carry-in-less ALU cannot do in one pass.
- Sits between the datapath issue logic and the ALU instance, which is instantiated alongside it.

---
 rtl/alu_op_sequencer.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue-side controller for the 32-bit combinational ALU.
// Accepts requests over a valid/ready handshake, decodes the opcode into the
// ALU controls word, drives registered operands, captures result/flags and
// returns them over an output valid/ready handshake.
// Optional feature macro: ALU_SEQ_SUB_EN enables the two-pass SUB opcode (10),
// which negates B on the first pass and adds A on the second. Without it,
// opcode 10 is reported as illegal and the second-pass state does not exist.
module alu_op_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [2:0]        out_flags,
    output logic              out_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        alu_flags,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [4:0] CTRL_ADD = 5'b00000;
    localparam logic [4:0] CTRL_NEG = 5'b01100;

`ifdef ALU_SEQ_SUB_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_EXEC2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DONE  = 2'd3
    } state_t;
`endif

    // Opcode to ALU controls word; illegal opcodes map to ADD so the ALU sees a
    // harmless code while the error response is being presented.
    function automatic logic [4:0] op_ctrl(input logic [3:0] op);
        case (op)
            4'd0:    op_ctrl = 5'b00000;
            4'd1:    op_ctrl = 5'b00001;
            4'd2:    op_ctrl = 5'b00010;
            4'd3:    op_ctrl = 5'b00011;
            4'd4:    op_ctrl = 5'b00111;
            4'd5:    op_ctrl = 5'b01011;
            4'd6:    op_ctrl = 5'b01111;
            4'd7:    op_ctrl = 5'b10000;
            4'd8:    op_ctrl = 5'b00100;
            4'd9:    op_ctrl = 5'b01100;
`ifdef ALU_SEQ_SUB_EN
            4'd10:   op_ctrl = CTRL_NEG;
`endif
            default: op_ctrl = CTRL_ADD;
        endcase
    endfunction

    // True for opcodes the sequencer can execute.
    function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_SEQ_SUB_EN
        op_legal = (op <= 4'd10);
`else
        op_legal = (op <= 4'd9);
`endif
    endfunction

`ifdef ALU_SEQ_SUB_EN
    // True for the two-pass subtract.
    function automatic logic op_is_sub(input logic [3:0] op);
        op_is_sub = (op == 4'd10);
    endfunction
`endif

    state_t              state_r;
    state_t              state_next_s;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_result_r;
    logic [2:0]          out_flags_r;
    logic                out_err_r;
    logic [DATA_W-1:0]   alu_a_r;
    logic [DATA_W-1:0]   alu_b_r;
    logic [4:0]          alu_ctrl_r;
    logic [CNT_W-1:0]    op_count_r;
    logic                accept_s;
    logic                consume_s;
`ifdef ALU_SEQ_SUB_EN
    logic [DATA_W-1:0]   a_r;
    logic                sub_r;
`endif

    assign accept_s  = in_valid & in_ready_r;
    assign consume_s = out_valid_r & out_ready;

    // Next-state decode for the issue/execute/respond sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (op_legal(in_op)) begin
                        state_next_s = ST_EXEC;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
`ifdef ALU_SEQ_SUB_EN
                if (sub_r) begin
                    state_next_s = ST_EXEC2;
                end else begin
                    state_next_s = ST_DONE;
                end
`else
                state_next_s = ST_DONE;
`endif
            end
`ifdef ALU_SEQ_SUB_EN
            ST_EXEC2: begin
                state_next_s = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (consume_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register; in_ready is registered from the next state so it is
    // high exactly while the FSM sits in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            in_ready_r <= (state_next_s == ST_IDLE);
        end
    end

    // Operand, ALU-drive, response and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {DATA_W{1'b0}};
            out_flags_r  <= 3'b000;
            out_err_r    <= 1'b0;
            alu_a_r      <= {DATA_W{1'b0}};
            alu_b_r      <= {DATA_W{1'b0}};
            alu_ctrl_r   <= CTRL_ADD;
            op_count_r   <= {CNT_W{1'b0}};
`ifdef ALU_SEQ_SUB_EN
            a_r          <= {DATA_W{1'b0}};
            sub_r        <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        alu_a_r    <= in_a;
                        alu_b_r    <= in_b;
                        alu_ctrl_r <= op_ctrl(in_op);
                        if (op_legal(in_op)) begin
                            out_err_r   <= 1'b0;
                            out_valid_r <= 1'b0;
                        end else begin
                            out_err_r    <= 1'b1;
                            out_result_r <= {DATA_W{1'b0}};
                            out_flags_r  <= 3'b000;
                            out_valid_r  <= 1'b1;
                        end
`ifdef ALU_SEQ_SUB_EN
                        a_r   <= in_a;
                        sub_r <= op_is_sub(in_op);
                        // Pass 1 of SUB computes -B, so A must not reach the ALU yet.
                        if (op_is_sub(in_op)) begin
                            alu_a_r <= {DATA_W{1'b0}};
                        end
`endif
                    end
                end
                ST_EXEC: begin
`ifdef ALU_SEQ_SUB_EN
                    if (sub_r) begin
                        // Feed -B back as the B operand and set up A + (-B).
                        alu_b_r    <= alu_result;
                        alu_a_r    <= a_r;
                        alu_ctrl_r <= CTRL_ADD;
                    end else begin
                        out_result_r <= alu_result;
                        out_flags_r  <= alu_flags;
                        out_err_r    <= 1'b0;
                        out_valid_r  <= 1'b1;
                    end
`else
                    out_result_r <= alu_result;
                    out_flags_r  <= alu_flags;
                    out_err_r    <= 1'b0;
                    out_valid_r  <= 1'b1;
`endif
                end
`ifdef ALU_SEQ_SUB_EN
                ST_EXEC2: begin
                    out_result_r <= alu_result;
                    out_flags_r  <= alu_flags;
                    out_err_r    <= 1'b0;
                    out_valid_r  <= 1'b1;
                end
`endif
                ST_DONE: begin
                    if (consume_s) begin
                        out_valid_r <= 1'b0;
                        op_count_r  <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        alu_ctrl_r  <= CTRL_ADD;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_flags  = out_flags_r;
    assign out_err    = out_err_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_ctrl   = alu_ctrl_r;
    assign op_count   = op_count_r;

endmodule
